// File: rtl/fetch_if.sv
// Instruction-memory request/ready bus between the fetch stage (master) and imem (slave).
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch.sv
// MIPS instruction-fetch stage: PC register, next-PC selection, imem handshake and F->D register.
// Wrong-path fetches still in flight on a redirect are drained in DROP before the new PC is issued.
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_f_i,
  input  logic        stall_d_i,
  input  logic        flush_d_i,
  input  logic        pc_src_d_i,
  input  logic [31:0] pc_branch_d_i,
  input  logic [2:0]  jump_d_i,
  input  logic [31:0] reg_jump_target_d_i,
  fetch_if.master     imem,
  output logic [31:0] pc_f_o,
  output logic [31:0] instr_d_o,
  output logic [31:0] pc_plus_4_d_o,
  output logic        valid_d_o
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] DROP = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus_4;
  logic        unused_link;

  // jr/jalr beats j/jal beats a taken branch; low target bits are not forced to zero.
  function automatic logic [31:0] redirect_target(
    input logic [2:0]  jump,
    input logic [31:0] reg_target,
    input logic [31:0] pcp4_d,
    input logic [31:0] instr_d,
    input logic [31:0] branch_target
  );
    if (jump[1])      return reg_target;
    else if (jump[0]) return {pcp4_d[31:28], instr_d[25:0], 2'b00};
    else              return branch_target;
  endfunction

  assign unused_link = jump_d_i[2];

  assign redirect  = ~stall_d_i & (pc_src_d_i | jump_d_i[0] | jump_d_i[1]);
  assign target    = redirect_target(jump_d_i, reg_jump_target_d_i, pcp4_q,
                                     instr_q, pc_branch_d_i);
  assign pc_plus_4 = pc_q + 32'd4;

  assign imem.imem_req  = ~rst_i;
  assign imem.imem_addr = pc_q;
  assign pc_f_o         = pc_q;
  assign instr_d_o      = instr_q;
  assign pc_plus_4_d_o  = pcp4_q;
  assign valid_d_o      = valid_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    instr_d = NOP_INSTR;
    pcp4_d  = 32'h0;
    valid_d = 1'b0;

    if (redirect) begin
      // The F->D word belongs to the wrong path; a request still waiting must finish first.
      if (imem.imem_ready) begin
        pc_d    = target;
        state_d = RUN;
      end else begin
        pend_d  = target;
        state_d = DROP;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (imem.imem_ready && !stall_f_i) pc_d = pc_plus_4;
        end
        DROP: begin
          if (imem.imem_ready) begin
            pc_d    = pend_q;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase

      if (stall_d_i) begin
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
      end else if (flush_d_i) begin
        instr_d = NOP_INSTR;
      end else if (state_q == RUN && imem.imem_ready && !stall_f_i) begin
        instr_d = imem.imem_rdata;
        pcp4_d  = pc_plus_4;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcp4_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage; imem returns (addr>>2)+1, except a j instruction at 0x1000.
module tb_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f, stall_d, flush_d, pc_src;
  logic [31:0] pc_branch, reg_target;
  logic [2:0]  jump;
  logic        ready;
  logic [31:0] pc_f, instr_d, pcp4_d;
  logic        valid_d;
  int          passed = 0;
  int          total  = 0;

  fetch_if bus();

  fetch dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .stall_f_i           (stall_f),
    .stall_d_i           (stall_d),
    .flush_d_i           (flush_d),
    .pc_src_d_i          (pc_src),
    .pc_branch_d_i       (pc_branch),
    .jump_d_i            (jump),
    .reg_jump_target_d_i (reg_target),
    .imem                (bus),
    .pc_f_o              (pc_f),
    .instr_d_o           (instr_d),
    .pc_plus_4_d_o       (pcp4_d),
    .valid_d_o           (valid_d)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h0800_0010;
    return (a >> 2) + 32'd1;
  endfunction

  assign bus.imem_ready = ready;
  always_comb bus.imem_rdata = mem_word(bus.imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_f = 0; stall_d = 0; flush_d = 0; pc_src = 0;
    pc_branch = 0; reg_target = 0; jump = 3'b000; ready = 1'b1;
    tick(); tick();
    total++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", bus.imem_req); else passed++;
    total++; if (pc_f !== 32'h0) $display("FAIL reset_pc got %h want 0", pc_f); else passed++;
    total++; if (valid_d !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_d); else passed++;
    total++; if (instr_d !== 32'h0) $display("FAIL reset_instr got %h want 0", instr_d); else passed++;
    rst = 1'b0; #1;
    total++; if (bus.imem_req !== 1'b1) $display("FAIL req_after_reset got %b want 1", bus.imem_req); else passed++;
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 2; k++) begin
      tick();
      total++; if (bus.imem_addr !== 32'(4*k)) $display("FAIL seq_addr got %h want %h", bus.imem_addr, 32'(4*k)); else passed++;
      total++; if (instr_d !== 32'(k)) $display("FAIL seq_instr got %h want %h", instr_d, 32'(k)); else passed++;
      total++; if (pcp4_d !== 32'(4*k)) $display("FAIL seq_pcp4 got %h want %h", pcp4_d, 32'(4*k)); else passed++;
      total++; if (valid_d !== 1'b1) $display("FAIL seq_valid got %b want 1", valid_d); else passed++;
    end
  endtask

  task automatic test_wait_states();
    ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (bus.imem_addr !== 32'h8) $display("FAIL wait_addr got %h want 8", bus.imem_addr); else passed++;
      total++; if (valid_d !== 1'b0) $display("FAIL wait_valid got %b want 0", valid_d); else passed++;
    end
    ready = 1'b1;
    tick();
    total++; if (bus.imem_addr !== 32'hC) $display("FAIL wait_next_addr got %h want c", bus.imem_addr); else passed++;
    total++; if (instr_d !== 32'h3 || pcp4_d !== 32'hC || valid_d !== 1'b1)
      $display("FAIL wait_deliver got %h/%h/%b want 3/c/1", instr_d, pcp4_d, valid_d); else passed++;
  endtask

  task automatic test_branch();
    pc_src = 1'b1; pc_branch = 32'h40;
    tick();
    pc_src = 1'b0;
    total++; if (bus.imem_addr !== 32'h40) $display("FAIL br_addr got %h want 40", bus.imem_addr); else passed++;
    total++; if (valid_d !== 1'b0) $display("FAIL br_bubble got %b want 0", valid_d); else passed++;
    tick();
    total++; if (instr_d !== 32'h11 || pcp4_d !== 32'h44 || valid_d !== 1'b1)
      $display("FAIL br_deliver got %h/%h/%b want 11/44/1", instr_d, pcp4_d, valid_d); else passed++;
  endtask

  task automatic test_jump_drop();
    pc_src = 1'b1; pc_branch = 32'h1000;
    tick();
    pc_src = 1'b0;
    tick();
    total++; if (instr_d !== 32'h0800_0010 || pcp4_d !== 32'h1004)
      $display("FAIL j_setup got %h/%h want 08000010/1004", instr_d, pcp4_d); else passed++;
    jump = 3'b001; ready = 1'b0;
    tick();
    jump = 3'b000;
    total++; if (bus.imem_addr !== 32'h1004) $display("FAIL drop_hold1 got %h want 1004", bus.imem_addr); else passed++;
    tick();
    total++; if (bus.imem_addr !== 32'h1004 || bus.imem_req !== 1'b1)
      $display("FAIL drop_hold2 got %h/%b want 1004/1", bus.imem_addr, bus.imem_req); else passed++;
    ready = 1'b1;
    tick();
    total++; if (bus.imem_addr !== 32'h40) $display("FAIL drop_target got %h want 40", bus.imem_addr); else passed++;
    total++; if (valid_d !== 1'b0) $display("FAIL drop_discard got %b want 0", valid_d); else passed++;
    tick();
    total++; if (instr_d !== 32'h11 || valid_d !== 1'b1) $display("FAIL drop_resume got %h/%b want 11/1", instr_d, valid_d); else passed++;
  endtask

  task automatic test_stall_flush();
    stall_f = 1'b1; stall_d = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (pc_f !== 32'h44) $display("FAIL stall_pc got %h want 44", pc_f); else passed++;
      total++; if (instr_d !== 32'h11 || pcp4_d !== 32'h44 || valid_d !== 1'b1)
        $display("FAIL stall_fd got %h/%h/%b want 11/44/1", instr_d, pcp4_d, valid_d); else passed++;
      total++; if (bus.imem_req !== 1'b1) $display("FAIL stall_req got %b want 1", bus.imem_req); else passed++;
    end
    stall_f = 1'b0; stall_d = 1'b0;
    tick();
    total++; if (instr_d !== 32'h12 || pcp4_d !== 32'h48 || pc_f !== 32'h48)
      $display("FAIL stall_release got %h/%h/%h want 12/48/48", instr_d, pcp4_d, pc_f); else passed++;
    flush_d = 1'b1;
    tick();
    flush_d = 1'b0;
    total++; if (valid_d !== 1'b0 || instr_d !== 32'h0 || pc_f !== 32'h4C)
      $display("FAIL flush got %b/%h/%h want 0/0/4c", valid_d, instr_d, pc_f); else passed++;
  endtask

  task automatic test_jr_reset();
    jump = 3'b010; reg_target = 32'h100; pc_src = 1'b1; pc_branch = 32'h40;
    tick();
    jump = 3'b000; pc_src = 1'b0;
    total++; if (bus.imem_addr !== 32'h100 || valid_d !== 1'b0)
      $display("FAIL jr_prio got %h/%b want 100/0", bus.imem_addr, valid_d); else passed++;
    stall_f = 1'b1; stall_d = 1'b1; pc_src = 1'b1; pc_branch = 32'h200;
    tick();
    stall_f = 1'b0; stall_d = 1'b0; pc_src = 1'b0;
    total++; if (bus.imem_addr !== 32'h100) $display("FAIL stall_blocks_redirect got %h want 100", bus.imem_addr); else passed++;
    jump = 3'b010; reg_target = 32'h300; ready = 1'b0;
    tick();
    reg_target = 32'h400;
    tick();
    jump = 3'b000; ready = 1'b1;
    total++; if (bus.imem_addr !== 32'h100) $display("FAIL drop_pend_hold got %h want 100", bus.imem_addr); else passed++;
    tick();
    total++; if (bus.imem_addr !== 32'h400 || valid_d !== 1'b0)
      $display("FAIL drop_overwrite got %h/%b want 400/0", bus.imem_addr, valid_d); else passed++;
    tick();
    total++; if (instr_d !== 32'h101 || pcp4_d !== 32'h404)
      $display("FAIL jr_deliver got %h/%h want 101/404", instr_d, pcp4_d); else passed++;
    jump = 3'b010; reg_target = 32'h500; ready = 1'b0;
    tick();
    jump = 3'b000; rst = 1'b1;
    tick();
    total++; if (bus.imem_addr !== 32'h0 || valid_d !== 1'b0 || bus.imem_req !== 1'b0)
      $display("FAIL rst_in_drop got %h/%b/%b want 0/0/0", bus.imem_addr, valid_d, bus.imem_req); else passed++;
    rst = 1'b0; ready = 1'b1;
    tick();
    total++; if (bus.imem_addr !== 32'h4 || instr_d !== 32'h1 || valid_d !== 1'b1)
      $display("FAIL rst_restart got %h/%h/%b want 4/1/1", bus.imem_addr, instr_d, valid_d); else passed++;
  endtask

  task automatic test_wrap();
    jump = 3'b010; reg_target = 32'hFFFF_FFFC;
    tick();
    jump = 3'b000;
    total++; if (bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_target got %h want fffffffc", bus.imem_addr); else passed++;
    tick();
    total++; if (bus.imem_addr !== 32'h0 || pcp4_d !== 32'h0 || instr_d !== 32'h4000_0000)
      $display("FAIL wrap got %h/%h/%h want 0/0/40000000", bus.imem_addr, pcp4_d, instr_d); else passed++;
    jump = 3'b010; reg_target = 32'h102;
    tick();
    jump = 3'b000;
    total++; if (bus.imem_addr !== 32'h102) $display("FAIL low_bits got %h want 102", bus.imem_addr); else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_branch();
    test_jump_drop();
    test_stall_flush();
    test_jr_reset();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
